// File: rtl/femto_soc_pkg.sv
// Shared constants for the femto SoC memory responder.
//   IO_SEL_BIT   : address bit selecting the IO region (0 = RAM, 1 = IO)
//   io_reg_e     : IO register offsets, decoded from mem_addr[4:2]
//   ST_*         : bit positions inside the STATUS register
//   status_word  : packs the FIFO status fields into a 32-bit read value
package femto_soc_pkg;

    localparam int IO_SEL_BIT = 22;

    typedef enum logic [2:0] {
        IO_LEDS   = 3'd0,
        IO_TXDATA = 3'd1,
        IO_STATUS = 3'd2,
        IO_CYCLE  = 3'd3,
        IO_RSVD4  = 3'd4,
        IO_RSVD5  = 3'd5,
        IO_RSVD6  = 3'd6,
        IO_RSVD7  = 3'd7
    } io_reg_e;

    localparam int ST_OVERFLOW  = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_FULL      = 2;
    localparam int ST_COUNT_LSB = 4;

    function automatic logic [31:0] status_word(input logic       overflow,
                                                input logic       empty,
                                                input logic       full,
                                                input logic [3:0] count);
        logic [31:0] w;
        w                       = '0;
        w[ST_OVERFLOW]          = overflow;
        w[ST_EMPTY]             = empty;
        w[ST_FULL]              = full;
        w[ST_COUNT_LSB +: 4]    = count;
        return w;
    endfunction

endpackage

// File: rtl/femto_txfifo.sv
// Byte-wide TX FIFO with occupancy count.
//   clk, resetn : clock, asynchronous active-low reset (clears pointers/count)
//   push        : write push_data this cycle (ignored when full unless popping)
//   push_data   : byte to enqueue
//   pop         : remove the head byte this cycle (ignored when empty)
//   head        : current head byte (valid while !empty)
//   full, empty : occupancy flags
//   count       : number of bytes stored, 0..DEPTH
module femto_txfifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = store[rd_ptr];

    // A push into a full FIFO still lands when the head leaves in the
    // same cycle: the freed slot is the one the write pointer points at.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/femto_mem_responder.sv
// Memory/IO responder for a small RISC-V style core bus.
//   clk, resetn : clock, asynchronous active-low reset
//   mem_addr    : byte address; bit IO_SEL_BIT selects RAM (0) or IO (1)
//   mem_rstrb   : read strobe, data returned on mem_rdata one cycle later
//   mem_wdata   : write data (lane-replicated by the core)
//   mem_wmask   : byte write enables, nonzero means a write this cycle
//   mem_rdata   : read data, held until the next read strobe
//   leds        : LED register
//   tx_data     : TX FIFO head byte
//   tx_valid    : TX FIFO non-empty
//   tx_ready    : downstream consumes tx_data when high with tx_valid
module femto_mem_responder
    import femto_soc_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int TXF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic [7:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(TXF_DEPTH) + 1;

    logic          is_io;
    logic          is_write;
    io_reg_e       io_reg;
    logic [AW-1:0] ram_idx;

    assign is_io    = mem_addr[IO_SEL_BIT];
    assign is_write = |mem_wmask;
    assign io_reg   = io_reg_e'(mem_addr[4:2]);
    assign ram_idx  = mem_addr[AW+1:2];

    // Upper address bits alias and the byte offset is ignored.
    logic unused_addr;
    assign unused_addr = ^{mem_addr[31:IO_SEL_BIT+1],
                           mem_addr[IO_SEL_BIT-1:AW+2],
                           mem_addr[1:0]};

    // RAM: no reset, contents survive resetn.
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (is_write && !is_io) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i]) begin
                    ram[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // TX FIFO
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign fifo_push = is_write && is_io && (io_reg == IO_TXDATA) && mem_wmask[0];
    assign fifo_pop  = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty;

    femto_txfifo #(
        .DEPTH (TXF_DEPTH)
    ) u_txfifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (mem_wdata[7:0]),
        .pop       (fifo_pop),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // STATUS count field is four bits wide and saturates.
    logic [31:0] count_ext;
    logic [3:0]  count_nib;

    assign count_ext = 32'(fifo_count);
    assign count_nib = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    logic overflow;
    logic overflow_clr;
    logic overflow_set;

    assign overflow_clr = is_write && is_io && (io_reg == IO_STATUS) && mem_wdata[ST_OVERFLOW];
    assign overflow_set = fifo_push && fifo_full && !fifo_pop;

    logic [31:0] cycle_cnt;

    // Read mux sees pre-edge state, giving read-before-write on collisions.
    logic [31:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (!is_io) begin
            rd_word = ram[ram_idx];
        end else begin
            case (io_reg)
                IO_LEDS:   rd_word = {24'h0, leds};
                IO_STATUS: rd_word = status_word(overflow, fifo_empty, fifo_full, count_nib);
                IO_CYCLE:  rd_word = cycle_cnt;
                default:   rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_rdata <= '0;
            leds      <= '0;
            overflow  <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (mem_rstrb) begin
                mem_rdata <= rd_word;
            end
            if (is_write && is_io && (io_reg == IO_LEDS) && mem_wmask[0]) begin
                leds <= mem_wdata[7:0];
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
